// File: rtl/gmii_pkg.sv
// Shared constants and types for the GMII receive path: framing bytes,
// Ethernet CRC-32 constants, receive FSM states and status-bit positions.
package gmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Register value left after running data plus a correct FCS through the CRC.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  // m_status = {len_err, crc_err, gmii_err}
  localparam int STAT_W        = 3;
  localparam int STAT_GMII_ERR = 0;
  localparam int STAT_CRC_ERR  = 1;
  localparam int STAT_LEN_ERR  = 2;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 advance by one byte (LSB of data first).
// Shared with the TX FCS inserter.
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Bit-serial LFSR unrolled over the eight data bits.
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, strips
// the FCS and emits each frame as a byte stream with a status beat on tlast.
// Handshake: m_tvalid marks a valid beat; there is no ready, the sink must
// accept every beat. m_tuser/m_status are meaningful only with m_tlast.
// Build option GMII_RX_FCS_PASS_EN: forward the FCS bytes (delay line of
// depth 1, tlast on the last FCS byte); checks are unchanged.
// dbg_state exposes the FSM state for debug and checkers.
module gmii_rx_framer
  import gmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
)(
  input  logic              gmii_rx_clk,
  input  logic              gmii_rx_rstn,
  input  logic [7:0]        gmii_rxd,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  input  logic              stat_clr,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic [STAT_W-1:0] m_status,
  output logic [CNT_W-1:0]  frame_good_cnt,
  output logic [CNT_W-1:0]  frame_bad_cnt,
  output state_t            dbg_state
);

`ifdef GMII_RX_FCS_PASS_EN
  localparam int DEPTH = 1;
`else
  localparam int DEPTH = 5;
`endif

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_EMIT = LEN_W'(DEPTH + 1);
  localparam logic [LEN_W-1:0] LEN_TAIL = LEN_W'(DEPTH);

  state_t              state_q, state_n;
  logic [7:0]          sr [DEPTH];
  logic [31:0]         crc_q, crc_n, crc_step;
  logic [LEN_W-1:0]    len_q, len_n, len_inc;
  logic                err_q, err_n;
  logic                shift_en;
  logic [7:0]          tdata_n;
  logic                tvalid_n, tlast_n, tuser_n;
  logic [STAT_W-1:0]   status_n, fin_status;
  logic                good_inc, bad_inc;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rxd),
    .crc_out (crc_step)
  );

  assign len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
  assign dbg_state = state_q;

  // Frame verdict, evaluated on the dv=0 cycle that ends a DATA run.
  always_comb begin
    fin_status                = '0;
    fin_status[STAT_LEN_ERR]  = (len_q < LEN_MIN) || (len_q > LEN_MAX);
    fin_status[STAT_CRC_ERR]  = (crc_q != CRC_RESIDUE);
    fin_status[STAT_GMII_ERR] = err_q;
  end

  // Next state, datapath updates and next registered outputs.
  always_comb begin
    state_n  = state_q;
    crc_n    = crc_q;
    len_n    = len_q;
    err_n    = err_q;
    shift_en = 1'b0;
    tdata_n  = '0;
    tvalid_n = 1'b0;
    tlast_n  = 1'b0;
    tuser_n  = 1'b0;
    status_n = '0;
    good_inc = 1'b0;
    bad_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gmii_rx_dv) begin
          if (!gmii_rx_er && gmii_rxd == PREAMBLE_BYTE) state_n = PRE;
          else                                          state_n = DROP;
        end
      end
      PRE: begin
        if (!gmii_rx_dv) begin
          state_n = IDLE;
          bad_inc = 1'b1;
        end else if (gmii_rx_er) begin
          state_n = DROP;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_n = DATA;
          crc_n   = CRC_INIT;
          len_n   = '0;
          err_n   = 1'b0;
        end else if (gmii_rxd != PREAMBLE_BYTE) begin
          state_n = DROP;
        end
      end
      DATA: begin
        if (gmii_rx_dv) begin
          shift_en = 1'b1;
          crc_n    = crc_step;
          len_n    = len_inc;
          err_n    = err_q | gmii_rx_er;
          // The oldest byte leaves the delay line once it is full.
          if (len_inc >= LEN_EMIT) begin
            tvalid_n = 1'b1;
            tdata_n  = sr[DEPTH-1];
          end
        end else begin
          state_n = IDLE;
          if (len_q >= LEN_TAIL) begin
            tvalid_n = 1'b1;
            tlast_n  = 1'b1;
            tdata_n  = sr[DEPTH-1];
            status_n = fin_status;
            tuser_n  = |fin_status;
            good_inc = ~|fin_status;
            bad_inc  = |fin_status;
          end else begin
            bad_inc  = 1'b1;
          end
        end
      end
      DROP: begin
        if (!gmii_rx_dv) begin
          state_n = IDLE;
          bad_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and per-frame accumulators.
  always_ff @(posedge gmii_rx_clk or negedge gmii_rx_rstn) begin
    if (!gmii_rx_rstn) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      crc_q   <= crc_n;
      len_q   <= len_n;
      err_q   <= err_n;
    end
  end

  // Byte delay line holding back the trailing FCS.
  always_ff @(posedge gmii_rx_clk or negedge gmii_rx_rstn) begin
    if (!gmii_rx_rstn) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (shift_en) begin
      sr[0] <= gmii_rxd;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  // Registered stream outputs.
  always_ff @(posedge gmii_rx_clk or negedge gmii_rx_rstn) begin
    if (!gmii_rx_rstn) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
      m_status <= '0;
    end else begin
      m_tdata  <= tdata_n;
      m_tvalid <= tvalid_n;
      m_tlast  <= tlast_n;
      m_tuser  <= tuser_n;
      m_status <= status_n;
    end
  end

  // Statistics counters; clear wins over a same-cycle increment, wrap on overflow.
  always_ff @(posedge gmii_rx_clk or negedge gmii_rx_rstn) begin
    if (!gmii_rx_rstn) begin
      frame_good_cnt <= '0;
      frame_bad_cnt  <= '0;
    end else if (stat_clr) begin
      frame_good_cnt <= '0;
      frame_bad_cnt  <= '0;
    end else begin
      if (good_inc) frame_good_cnt <= frame_good_cnt + 1'b1;
      if (bad_inc)  frame_bad_cnt  <= frame_bad_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer (default build: FCS stripped).
module tb_gmii_rx_framer;
  import gmii_pkg::*;

  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic             rstn;
  logic [7:0]       rxd;
  logic             dv, er, stat_clr;
  logic [7:0]       m_tdata;
  logic             m_tvalid, m_tlast, m_tuser;
  logic [2:0]       m_status;
  logic [CNT_W-1:0] good_cnt, bad_cnt;
  state_t           dbg_state;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
    .gmii_rx_clk    (clk),
    .gmii_rx_rstn   (rstn),
    .gmii_rxd       (rxd),
    .gmii_rx_dv     (dv),
    .gmii_rx_er     (er),
    .stat_clr       (stat_clr),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tuser        (m_tuser),
    .m_status       (m_status),
    .frame_good_cnt (good_cnt),
    .frame_bad_cnt  (bad_cnt),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];   // {tlast, tdata}
  logic [2:0] stat_q[$];  // status expected on each tlast
  logic [7:0] frm[$];     // frame bytes after the SFD, FCS included

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  logic [8:0] mon_e;
  logic [2:0] mon_s;
  always @(negedge clk) begin
    if (rstn && m_tvalid) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", {24'h0, m_tdata}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("tdata", {24'h0, m_tdata}, {24'h0, mon_e[7:0]});
        check("tlast", {31'h0, m_tlast}, {31'h0, mon_e[8]});
        if (mon_e[8]) begin
          mon_s = (stat_q.size() != 0) ? stat_q.pop_front() : 3'bxxx;
          check("status", {29'h0, m_status}, {29'h0, mon_s});
          check("tuser", {31'h0, m_tuser}, {31'h0, |mon_s});
        end
      end
    end else if (rstn && (m_tlast || m_status != 3'b000)) begin
      check("idle_side", {28'h0, m_tlast, m_status}, 32'h0);
    end
  end

  // ---------------- frame builders ----------------
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = ((r[0] ^ b[k]) != 1'b0) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_ramp(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(i[7:0]);
  endtask

  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_byte(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic push_exp(input int n, input logic [2:0] st, input bit with_last);
    logic l;
    for (int i = 0; i < n; i++) begin
      l = with_last && (i == n - 1);
      exp_q.push_back({l, frm[i]});
    end
    if (with_last) stat_q.push_back(st);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit v, input bit e, input logic [7:0] d);
    @(negedge clk);
    dv  = v;
    er  = e;
    rxd = d;
  endtask

  task automatic send_frame(input int er_idx, input int bad_pre, input bit clr_end);
    for (int p = 0; p < 7; p++) drive(1'b1, 1'b0, (p == bad_pre) ? 8'h5D : 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, i == er_idx, frm[i]);
    @(negedge clk);
    dv = 1'b0; er = 1'b0; rxd = 8'h00; stat_clr = clr_end;
    @(negedge clk);
    stat_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_after(input string tag, input int g, input int b);
    check({tag, "_good"}, good_cnt, g);
    check({tag, "_bad"}, bad_cnt, b);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; rxd = 8'h00; dv = 1'b0; er = 1'b0; stat_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", {31'h0, m_tvalid}, 0);
    check("rst_tdata",  {24'h0, m_tdata}, 0);
    check("rst_tlast",  {31'h0, m_tlast}, 0);
    check("rst_tuser",  {31'h0, m_tuser}, 0);
    check("rst_status", {29'h0, m_status}, 0);
    check("rst_good",   good_cnt, 0);
    check("rst_bad",    bad_cnt, 0);
    check("rst_state",  {30'h0, dbg_state}, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1) good 64-byte frame
    build_ramp(60); append_fcs();
    push_exp(60, 3'b000, 1);
    send_frame(-1, -1, 0);
    check_after("good64", 1, 0);

    // 2) runt "123456789" with correct FCS
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'h31 + i[7:0]);
    frm.push_back(8'h26); frm.push_back(8'h39); frm.push_back(8'hF4); frm.push_back(8'hCB);
    push_exp(9, 3'b100, 1);
    send_frame(-1, -1, 0);
    check_after("runt", 1, 1);

    // 3) 64-byte frame, one payload bit flipped after FCS computed
    build_ramp(60); append_fcs();
    frm[5] = frm[5] ^ 8'h04;
    push_exp(60, 3'b010, 1);
    send_frame(-1, -1, 0);
    check_after("crcbad", 1, 2);

    // 4) 100-byte frame with rx_er on byte 10
    build_ramp(96); append_fcs();
    push_exp(96, 3'b001, 1);
    send_frame(10, -1, 0);
    check_after("rxer", 1, 3);

    // 5) corrupted preamble byte: dropped, nothing emitted
    build_ramp(60); append_fcs();
    send_frame(-1, 3, 0);
    check_after("badpre", 1, 4);

    // 6) back-to-back: good frame then 1519-byte frame
    build_ramp(60); append_fcs();
    push_exp(60, 3'b000, 1);
    send_frame(-1, -1, 0);
    build_ramp(1515); append_fcs();
    push_exp(1515, 3'b100, 1);
    send_frame(-1, -1, 0);
    check_after("long", 2, 5);

    // 7) stat_clr coincident with the good-frame increment
    build_ramp(60); append_fcs();
    push_exp(60, 3'b000, 1);
    send_frame(-1, -1, 1);
    check_after("clr", 0, 0);

    // 8) reset at payload byte 30; beats for bytes 0..24 already out
    build_ramp(60); append_fcs();
    push_exp(25, 3'b000, 0);
    for (int p = 0; p < 7; p++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1'b1, 1'b0, frm[i]);
      if (i == 30) begin #2 rstn = 1'b0; end
      if (i == 31) check("inrst_tvalid", {31'h0, m_tvalid}, 0);
      if (i == 33) begin #2 rstn = 1'b1; end
    end
    @(negedge clk);
    dv = 1'b0; rxd = 8'h00;
    repeat (11) @(negedge clk);
    check_after("rstmid", 0, 1);
    build_ramp(60); append_fcs();
    push_exp(60, 3'b000, 1);
    send_frame(-1, -1, 0);
    check_after("postrst", 1, 1);

    check("stat_left", stat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
